// File: rtl/ili9341_frame_monitor.sv
// Pixel-stream monitor for the ILI9341 path: checks frame length and colour uniformity, and decodes the frame colour to a state code.
// Optional FRAME_MON_CHECKSUM_EN: per-frame 16-bit pixel checksum on frame_sum (constant 0 otherwise).
module ili9341_frame_monitor #(
    parameter int RESOLUTION = 100,
    parameter int PIXEL_SIZE = 16
) (
    input  logic                  clk_input_data,
    input  logic                  rst,
    input  logic [PIXEL_SIZE-1:0] pixel_in,
    input  logic                  frame_done,
    output logic                  frame_valid,
    output logic [PIXEL_SIZE-1:0] frame_color,
    output logic [2:0]            state_code,
    output logic                  uniform,
    output logic                  count_err,
    output logic [15:0]           frame_count,
    output logic [7:0]            error_count,
    output logic                  locked,
    output logic [15:0]           frame_sum
);
    localparam int            CW           = $clog2(RESOLUTION + 1);
    localparam logic [CW-1:0] RES_C        = CW'(RESOLUTION);
    localparam logic [2:0]    CODE_UNKNOWN = 3'd7;

    typedef enum logic {SYNC, CAPTURE} state_t;

    function automatic logic [15:0] to16(input logic [PIXEL_SIZE-1:0] px);
        return 16'(px);
    endfunction

    function automatic logic [2:0] palette(input logic [PIXEL_SIZE-1:0] px);
        logic [2:0] code;
        code = CODE_UNKNOWN;
        if (PIXEL_SIZE == 16) begin
            case (to16(px))
                16'hFFE0: code = 3'd0;
                16'h07FF: code = 3'd1;
                16'hF800: code = 3'd2;
                16'h780F: code = 3'd3;
                16'h0000: code = 3'd4;
                16'h001F: code = 3'd5;
                default:  code = CODE_UNKNOWN;
            endcase
        end
        return code;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    uni_q, uni_d;
    logic [PIXEL_SIZE-1:0]   first_px_q, first_px_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [PIXEL_SIZE-1:0]   frame_color_q, frame_color_d;
    logic [2:0]              state_code_q, state_code_d;
    logic                    uniform_q, uniform_d;
    logic                    count_err_q, count_err_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [7:0]              error_count_q, error_count_d;

    logic report, overrun, sample;
    logic frame_ok;

    assign report   = (state_q == CAPTURE) && frame_done;
    assign overrun  = (state_q == CAPTURE) && !frame_done && (cnt_q == RES_C);
    assign sample   = (state_q == CAPTURE) && !frame_done && (cnt_q != RES_C);
    // A frame with no pixels can never be uniform, whatever uni_q holds.
    assign frame_ok = uni_q && (cnt_q != '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        uni_d         = uni_q;
        first_px_d    = first_px_q;
        frame_valid_d = 1'b0;
        frame_color_d = frame_color_q;
        state_code_d  = state_code_q;
        uniform_d     = uniform_q;
        count_err_d   = count_err_q;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;

        if (frame_done) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            uni_d   = 1'b0;
        end

        if (report) begin
            frame_valid_d = 1'b1;
            frame_color_d = first_px_q;
            uniform_d     = frame_ok;
            count_err_d   = (cnt_q != RES_C);
            state_code_d  = frame_ok ? palette(first_px_q) : CODE_UNKNOWN;
            frame_count_d = frame_count_q + 16'd1;
            if (cnt_q != RES_C) error_count_d = sat_inc8(error_count_q);
        end else if (overrun) begin
            state_d       = SYNC;
            cnt_d         = '0;
            uni_d         = 1'b0;
            count_err_d   = 1'b1;
            error_count_d = sat_inc8(error_count_q);
        end else if (sample) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
                first_px_d = pixel_in;
                uni_d      = 1'b1;
            end else begin
                uni_d = uni_q && (pixel_in == first_px_q);
            end
        end
    end

    always_ff @(posedge clk_input_data) begin
        if (!rst) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            uni_q         <= 1'b0;
            first_px_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_color_q <= '0;
            state_code_q  <= CODE_UNKNOWN;
            uniform_q     <= 1'b0;
            count_err_q   <= 1'b0;
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            uni_q         <= uni_d;
            first_px_q    <= first_px_d;
            frame_valid_q <= frame_valid_d;
            frame_color_q <= frame_color_d;
            state_code_q  <= state_code_d;
            uniform_q     <= uniform_d;
            count_err_q   <= count_err_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
        end
    end

`ifdef FRAME_MON_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if (frame_done) begin
            sum_d = '0;
            if (report) frame_sum_d = sum_q;
        end else if (overrun) begin
            sum_d = '0;
        end else if (sample) begin
            sum_d = sum_q + to16(pixel_in);
        end
    end

    always_ff @(posedge clk_input_data) begin
        if (!rst) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = 16'd0;
`endif

    assign frame_valid = frame_valid_q;
    assign frame_color = frame_color_q;
    assign state_code  = state_code_q;
    assign uniform     = uniform_q;
    assign count_err   = count_err_q;
    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
    assign locked      = (state_q == CAPTURE);

endmodule

// File: doc/ili9341_frame_monitor.md
Name: ili9341_frame_monitor

Overview:
- Reader/decoder on the pixel-stream side of the ILI9341 path.
- Observes the per-pixel stream (pixel word plus frame_done boundary pulse) that the top-level streamer presents to the SPI controller on clk_input_data.
- Checks framing, checks colour uniformity, and decodes the frame colour back to the 3-bit visualisation state code.
- Used in-system for status LEDs and as a self-checking monitor in benches.

Parameters:
- RESOLUTION, 100, pixels expected per frame.
- PIXEL_SIZE, 16, pixel word width; the palette decode is defined only for 16.

Ports:
- clk_input_data  in  1  pixel/data clock from the SPI controller.
- rst  in  1  synchronous, active-low reset.
- pixel_in  in  PIXEL_SIZE  pixel word, sampled every edge with frame_done==0.
- frame_done  in  1  frame boundary; high one cycle, no pixel sampled on that edge.
- frame_valid  out  1  one-cycle pulse: results for the just-closed frame.
- frame_color  out  PIXEL_SIZE  first pixel of the last reported frame.
- state_code  out  3  decoded state: 0 yellow, 1 light blue, 2 red, 3 purple, 4 black, 5 dark blue, 7 unknown or non-uniform.
- uniform  out  1  every pixel of the last reported frame equalled its first pixel.
- count_err  out  1  the last reported or aborted frame had pixel count != RESOLUTION.
- frame_count  out  16  frames reported; wraps at 0xFFFF->0.
- error_count  out  8  frames with count_err; saturates at 0xFF.
- locked  out  1  high while in CAPTURE.
- frame_sum  out  16  checksum; see Optional Feature.

Behaviour:
- Reset (rst==0 at an edge):
  - All outputs go to 0, except state_code = 7.
  - Internal pixel counter and uniform accumulator are cleared.
  - FSM goes to SYNC.
  - Reset mid-frame discards the partial frame.
- FSM states: SYNC and CAPTURE.
- SYNC:
  - Ignores pixels; locked = 0.
  - On frame_done==1, go to CAPTURE with the counter at 0. No report is produced for this boundary.
- CAPTURE, frame_done==0 edge:
  - cnt += 1.
  - If cnt==0, latch first_px = pixel_in and set uni = 1.
  - Otherwise uni &= (pixel_in == first_px).
  - Counter width is $clog2(RESOLUTION+1).
- CAPTURE, frame_done==1 edge (report):
  - Register frame_color = first_px and uniform = uni (uniform = 0 if cnt==0).
  - count_err = (cnt != RESOLUTION).
  - state_code = palette(first_px) if uni and cnt != 0, else 7.
  - frame_count += 1; error_count += count_err (saturating).
  - frame_valid = 1 for exactly the next cycle. Outputs become visible one edge after the frame_done edge.
  - Counter and accumulator clear; FSM stays in CAPTURE.
- Back-to-back frame_done pulses produce a report with cnt==0: count_err = 1, uniform = 0, state_code = 7.
- Overrun: a pixel arriving in CAPTURE with cnt==RESOLUTION:
  - count_err = 1; error_count += 1 (saturating); frame_valid stays 0.
  - frame_count unchanged; other result outputs hold their previous values.
  - FSM goes to SYNC.
- Palette (exact 16-bit match): FFE0->0, 07FF->1, F800->2, 780F->3, 0000->4, 001F->5, anything else->7.
- Result outputs hold their values between reports; frame_valid is 0 except in the report cycle.

Optional Feature:
- Macro: FRAME_MON_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator adds each sampled pixel (zero-extended or truncated to 16 bits) modulo 2^16.
  - The accumulator clears at reset, on every frame_done, and on overrun.
  - frame_sum is registered at report together with the other results.
- Undefined: frame_sum is constant 0 and no accumulator logic is generated.

Test Plan:
- Reset, then frame_done, then 100x F800, then frame_done -> the first boundary produces no report; at the second: frame_valid one cycle, frame_color=F800, state_code=2, uniform=1, count_err=0, frame_count=1.
- Sync, then 100 pixels 07FF with pixel #50 = 0000, then frame_done -> uniform=0, state_code=7, frame_color=07FF, count_err=0.
- Sync, then 99x FFE0, then frame_done -> frame_valid pulses, count_err=1, error_count=1, state_code=0, uniform=1.
- Sync, then 101x 0000 with no frame_done -> at pixel 101: count_err=1, error_count=1, locked=0, no frame_valid. Then frame_done, 100x 0000, frame_done -> state_code=4, count_err=0.
- rst=0 after 40 pixels, then released -> next edge: all outputs 0, state_code=7, locked=0. A full frame after resync reports normally with frame_count=1.
- FRAME_MON_CHECKSUM_EN defined: 100x 780F framed -> frame_sum=E5DC. Macro undefined -> frame_sum=0.
